// File: rtl/icache_dm_if.sv
//------------------------------------------------------------------------------
// icache_dm_if : fetch-side and refill-side handshake bundle for icache_dm
// Revision     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface icache_dm_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              flush;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid;
  logic [31:0]       mem_resp_data;

  modport slave (
    input  req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    output req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr
  );

  modport master (
    output req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr
  );
endinterface

`default_nettype wire

// File: rtl/icache_dm.sv
//------------------------------------------------------------------------------
// icache_dm : direct-mapped instruction cache, 1-cycle hits, burst line refill
//             Optional hit/miss counters enabled by ICACHE_STATS_EN.
// Revision  : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module icache_dm #(
  parameter int ADDR_W     = 32,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  icache_dm_if.slave        bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int c_WORD_W = $clog2(LINE_WORDS);
  localparam int c_IDX_W  = $clog2(SETS);
  localparam int c_OFF_W  = 2 + c_WORD_W;
  localparam int c_TAG_W  = ADDR_W - c_OFF_W - c_IDX_W;
  localparam logic [c_WORD_W-1:0] c_LAST = c_WORD_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [SETS-1:0]     r_valid;
  logic [c_TAG_W-1:0]  r_tags [SETS];
  logic [31:0]         r_data [SETS*LINE_WORDS];

  logic [c_IDX_W-1:0]  r_idx;
  logic [c_TAG_W-1:0]  r_tag;
  logic [c_WORD_W-1:0] r_word;
  logic [c_WORD_W-1:0] r_cnt;
  logic                r_flush_pend;
  logic                r_resp_valid;
  logic [31:0]         r_resp_data;
  logic [ADDR_W-1:0]   r_mem_addr;

  logic [c_IDX_W-1:0]  w_idx;
  logic [c_TAG_W-1:0]  w_tag;
  logic [c_WORD_W-1:0] w_word;
  logic                w_accept;
  logic                w_hit;
  logic                w_beat;
  logic                w_last;
  logic                w_unused_addr_bits;

  assign w_idx    = bus.req_addr[c_OFF_W +: c_IDX_W];
  assign w_tag    = bus.req_addr[ADDR_W-1 -: c_TAG_W];
  assign w_word   = bus.req_addr[2 +: c_WORD_W];
  assign w_unused_addr_bits = &{1'b0, bus.req_addr[1:0]};

  assign w_accept = (r_state == ST_IDLE) && bus.req_valid;
  // A flush on the accepting edge forces a miss even if the line was valid.
  assign w_hit    = r_valid[w_idx] && (r_tags[w_idx] == w_tag) && !bus.flush;
  assign w_beat   = (r_state == ST_FILL) && bus.mem_resp_valid;
  assign w_last   = w_beat && (r_cnt == c_LAST);

  assign bus.req_ready     = (r_state == ST_IDLE);
  assign bus.mem_req_valid = (r_state == ST_REQ);
  assign bus.mem_req_addr  = r_mem_addr;
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_data     = r_resp_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && !w_hit) w_next = ST_REQ;
      ST_REQ:  if (bus.mem_req_ready)  w_next = ST_FILL;
      ST_FILL: if (w_last)             w_next = ST_RESP;
      ST_RESP:                         w_next = ST_IDLE;
      default:                         w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid      <= '0;
      r_idx        <= '0;
      r_tag        <= '0;
      r_word       <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_mem_addr   <= '0;
    end else begin
      r_resp_valid <= (w_accept && w_hit) || w_last;

      // Deferred flush lands on the RESP->IDLE edge, after the word is delivered.
      if ((r_state == ST_IDLE) && bus.flush)
        r_valid <= '0;
      else if ((r_state == ST_RESP) && (r_flush_pend || bus.flush))
        r_valid <= '0;
      else if (w_last)
        r_valid[r_idx] <= 1'b1;

      if (r_state == ST_RESP)
        r_flush_pend <= 1'b0;
      else if ((r_state != ST_IDLE) && bus.flush)
        r_flush_pend <= 1'b1;

      if (w_accept && w_hit)
        r_resp_data <= r_data[{w_idx, w_word}];
      else if (w_beat && (r_cnt == r_word))
        r_resp_data <= bus.mem_resp_data;

      if (w_accept && !w_hit) begin
        r_idx      <= w_idx;
        r_tag      <= w_tag;
        r_word     <= w_word;
        r_cnt      <= '0;
        r_mem_addr <= {w_tag, w_idx, {c_OFF_W{1'b0}}};
      end else if (w_beat) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat) r_data[{r_idx, r_cnt}] <= bus.mem_resp_data;
    if (w_last) r_tags[r_idx]          <= r_tag;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (bus.flush) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_accept) begin
      if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else       r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_dm.sv
//------------------------------------------------------------------------------
// tb_icache_dm : directed self-checking bench for icache_dm (SETS=64, LINE_WORDS=4)
// Revision     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_icache_dm;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  icache_dm_if #(.ADDR_W(32)) bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_dm #(.ADDR_W(32), .SETS(64), .LINE_WORDS(4)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fetch_hit(input logic [31:0] a, input logic [31:0] exp);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    step();
    bus.req_valid = 1'b0;
    chk("hit_valid", bus.resp_valid, 1);
    chk("hit_data", bus.resp_data, exp);
    chk("hit_no_mem_req", bus.mem_req_valid, 0);
    step();
    chk("hit_pulse_end", bus.resp_valid, 0);
  endtask

  // Beats are base, base+0x80, base+0x100, base+0x180; flush pulses in the first gap cycle before beat flush_at.
  task automatic fetch_miss(input logic [31:0] a, input logic [31:0] line, input logic [31:0] base,
                            input int wait_rdy, input int gap, input int flush_at,
                            input logic [31:0] exp);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    step();
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    chk("miss_no_resp", bus.resp_valid, 0);
    chk("miss_req_valid", bus.mem_req_valid, 1);
    chk("miss_req_addr", bus.mem_req_addr, line);
    chk("miss_not_ready", bus.req_ready, 0);
    for (int i = 0; i < wait_rdy; i++) begin
      step();
      chk("req_hold_valid", bus.mem_req_valid, 1);
      chk("req_hold_addr", bus.mem_req_addr, line);
    end
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    chk("fill_req_drop", bus.mem_req_valid, 0);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        bus.flush = (b == flush_at) && (g == 0);
        step();
        bus.flush = 1'b0;
        chk("gap_no_resp", bus.resp_valid, 0);
      end
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = base + 32'(b) * 32'h80;
      step();
      bus.mem_resp_valid = 1'b0;
      chk((b == 3) ? "last_beat_resp" : "early_beat_no_resp", bus.resp_valid, (b == 3));
    end
    chk("refill_data", bus.resp_data, exp);
    step();
    chk("refill_pulse_end", bus.resp_valid, 0);
    chk("back_to_idle", bus.req_ready, 1);
  endtask

  initial begin
    rst                = 1'b0;
    bus.req_valid      = 1'b0;
    bus.req_addr       = '0;
    bus.flush          = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    chk("rst_mem_req_valid", bus.mem_req_valid, 0);
    chk("rst_mem_req_addr", bus.mem_req_addr, 0);
`ifdef ICACHE_STATS_EN
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
`endif
    step();

    // Cold miss on 0x100 returns word 0 of the refilled line.
    fetch_miss(32'h100, 32'h100, 32'h13, 0, 0, -1, 32'h13);
    // Word 3 of the same line hits.
    fetch_hit(32'h10C, 32'h193);
`ifdef ICACHE_STATS_EN
    chk("stats_hit1", hit_cnt, 1);
    chk("stats_miss1", miss_cnt, 1);
`endif

    // 0x500 shares index 16 with 0x100 and evicts it.
    fetch_hit(32'h100, 32'h13);
    fetch_miss(32'h500, 32'h500, 32'h51, 0, 0, -1, 32'h51);
    // Refetch of the evicted line: slow request accept and gapped beats.
    fetch_miss(32'h108, 32'h100, 32'h13, 5, 2, -1, 32'h113);
    fetch_hit(32'h10C, 32'h193);

    // Last set and set 0 hold lines independently.
    fetch_miss(32'h3FC, 32'h3F0, 32'h31, 0, 0, -1, 32'h1B1);
    fetch_miss(32'h400, 32'h400, 32'h41, 0, 1, -1, 32'h41);
    fetch_hit(32'h3F0, 32'h31);
    fetch_hit(32'h404, 32'hC1);

    // Flush during FILL: word still delivered, line invalid afterwards.
    fetch_miss(32'h204, 32'h200, 32'h22, 0, 1, 2, 32'hA2);
`ifdef ICACHE_STATS_EN
    chk("stats_flush_clear", hit_cnt, 0);
`endif
    fetch_miss(32'h204, 32'h200, 32'h23, 0, 0, -1, 32'hA3);
    // Flush in IDLE with a request on the same edge forces a miss.
    bus.flush = 1'b1;
    fetch_miss(32'h204, 32'h200, 32'h24, 0, 0, -1, 32'hA4);
    fetch_hit(32'h204, 32'hA4);
    // The earlier IDLE flush also dropped the 0x100 line.
    fetch_miss(32'h100, 32'h100, 32'h15, 0, 0, -1, 32'h15);

    // Asynchronous reset in the middle of a refill.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h600;
    step();
    bus.req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h61;
    step();
    bus.mem_resp_data  = 32'hE1;
    step();
    bus.mem_resp_data  = 32'h161;
    rst = 1'b0;
    #1;
    chk("arst_resp_valid", bus.resp_valid, 0);
    chk("arst_resp_data", bus.resp_data, 0);
    chk("arst_mem_req_valid", bus.mem_req_valid, 0);
    chk("arst_mem_req_addr", bus.mem_req_addr, 0);
    chk("arst_req_ready", bus.req_ready, 1);
`ifdef ICACHE_STATS_EN
    chk("arst_hit_cnt", hit_cnt, 0);
    chk("arst_miss_cnt", miss_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    bus.mem_resp_data = 32'h1E1;
    step();
    chk("stray_beat_no_resp", bus.resp_valid, 0);
    step();
    chk("stray_beat2_no_resp", bus.resp_valid, 0);
    bus.mem_resp_valid = 1'b0;
    fetch_miss(32'h600, 32'h600, 32'h71, 0, 0, -1, 32'h71);
    fetch_miss(32'h104, 32'h100, 32'h17, 0, 0, -1, 32'h97);
`ifdef ICACHE_STATS_EN
    chk("stats_after_rst_miss", miss_cnt, 2);
    chk("stats_after_rst_hit", hit_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
